tx_lane_scheduler: RTL and testbench
====================================

TX_LANE_SCHEDULER -- requirements
Module: tx_lane_scheduler

Interface
- REQ-001: Parameter WORD_W, default 132: width of each lane parallel word.
- REQ-002: Parameter WDOG, default 255: max cycles between word_tick pulses in RUN before wdog_err.
- REQ-003: clk  input  1  clock; all logic rising-edge.
- REQ-004: rst  input  1  asynchronous, active-low reset.
- REQ-005: tx_en  input  1  link layer requests transmission.
- REQ-006: gen_speed  input  2  requested speed: 00 = 8-bit word period, 01 = 132, 10 = 66, 11 treated as 00.
- REQ-007: word_tick  input  1  one-cycle pulse from the serializer, asserted the cycle after it loads a word.
- REQ-008: os_req  input  1  ordered-set source has a word pending.
- REQ-009: os_l0, os_l1  input  WORD_W  ordered-set words for lanes 0 and 1.
- REQ-010: data_valid  input  1  transport source has a word pending.
- REQ-011: data_last  input  1  current data word ends the burst.
- REQ-012: data_l0, data_l1  input  WORD_W  transport words for lanes 0 and 1.
- REQ-013: ser_enable  output  1  serializer enable.
- REQ-014: ser_gen_speed  output  2  latched speed driven to the serializer.
- REQ-015: lane0_word, lane1_word  output  WORD_W  registered words presented to the serializer.
- REQ-016: os_ack, data_ack  output  1  one-cycle pulse: the source's word was captured.
- REQ-017: underrun  output  1  sticky: idle fill was inserted mid data burst.
- REQ-018: wdog_err  output  1  sticky: word_tick missing for WDOG cycles in RUN.
- REQ-019: busy  output  1  high in every state except IDLE.

Function
- REQ-020: FSM states: IDLE, ARM, RUN, DRAIN; all outputs registered.
- REQ-021: IDLE: ser_enable=0. On tx_en=1, latch gen_speed into ser_gen_speed, capture the first selected word into lane words, and go to ARM.
- REQ-022: ARM lasts exactly 1 cycle, then RUN with ser_enable=1. The first word is therefore stable one cycle before enable rises.
- REQ-023: RUN, each word_tick: capture the next selected word into lane0_word/lane1_word (visible the cycle after the tick) and pulse the matching ack in that same capture cycle.
- REQ-024: Selection when not in a data burst: os_req first, then data_valid (opens a burst), else idle fill (all-zero words, no ack).
- REQ-025: In a data burst, data has priority over os_req. The burst closes when a captured word has data_last=1.
- REQ-026: data_valid=0 at a capture while in a burst: insert idle fill, set underrun, keep the burst open.
- REQ-027: Simultaneous os_req and data_valid outside a burst: OS wins, data waits; no ack to data.
- REQ-028: RUN to DRAIN when tx_en=0, or when gen_speed differs from ser_gen_speed (11 compared as 00).
- REQ-029: DRAIN: capture idle fill at the next word_tick, with no acks.
- REQ-030: DRAIN exit, on the word_tick following that capture: ser_enable=0 for at least 1 cycle, then IDLE.
- REQ-031: A burst open at DRAIN entry is abandoned; underrun is not set.
- REQ-032: IDLE re-arms with the newly latched speed if tx_en is still 1; ser_gen_speed changes only in IDLE.
- REQ-033: Watchdog counter: cleared on word_tick and outside RUN; counts in RUN. At WDOG it sets wdog_err and saturates; the FSM continues.
- REQ-034: Acks never assert in IDLE, ARM or DRAIN, except the first-word capture on IDLE exit.

Reset
- REQ-035: rst=0 asynchronously forces IDLE, ser_enable=0, ser_gen_speed=00, lane words=0, acks=0, underrun=0, wdog_err=0, busy=0, burst flag and watchdog counter cleared.
- REQ-036: Reset mid-RUN abandons any word in flight; no ack is issued for it.
- REQ-037: Sticky flags clear only on reset.

Verification
- REQ-038: gen_speed=00, tx_en=1, os_req=1 with os_l0=0xA5 -> os_ack pulses with lane0_word=0xA5, then ARM, then ser_enable=1 on the 3rd cycle.
- REQ-039: RUN; data burst of 3 words, last flagged; os_req=1 throughout -> data_ack on 3 consecutive ticks, then os_ack on the 4th tick.
- REQ-040: Burst open, data_valid=0 at a tick -> lane words=0, no ack, underrun=1 and held.
- REQ-041: RUN at gen_speed=00, switch to 10 -> idle captured at next tick, ser_enable low 1+ cycle after the following tick, ser_gen_speed=10, re-enable with the first word held one cycle ahead.
- REQ-042: RUN, word_tick held 0 for 255 cycles -> wdog_err=1. Then rst pulse mid-RUN -> all outputs return to the REQ-035 values immediately.

Source files
------------

// File: rtl/tx_lane_scheduler.sv
// Two-lane transmit word scheduler: arbitrates ordered sets against transport
// bursts, paces captures on serializer word ticks and sequences link enable.
module tx_lane_scheduler #(
  parameter int WORD_W = 132,
  parameter int WDOG   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic [1:0]        gen_speed,
  input  logic              word_tick,
  input  logic              os_req,
  input  logic [WORD_W-1:0] os_l0,
  input  logic [WORD_W-1:0] os_l1,
  input  logic              data_valid,
  input  logic              data_last,
  input  logic [WORD_W-1:0] data_l0,
  input  logic [WORD_W-1:0] data_l1,
  output logic              ser_enable,
  output logic [1:0]        ser_gen_speed,
  output logic [WORD_W-1:0] lane0_word,
  output logic [WORD_W-1:0] lane1_word,
  output logic              os_ack,
  output logic              data_ack,
  output logic              underrun,
  output logic              wdog_err,
  output logic              busy
);

  localparam int CW = $clog2(WDOG + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic              burst_q, burst_d;
  logic              drain_cap_q, drain_cap_d;
  logic [CW-1:0]     wdog_cnt_q, wdog_cnt_d;
  logic              ser_enable_q, ser_enable_d;
  logic [1:0]        ser_gen_speed_q, ser_gen_speed_d;
  logic [WORD_W-1:0] lane0_q, lane0_d, lane1_q, lane1_d;
  logic              os_ack_q, os_ack_d, data_ack_q, data_ack_d;
  logic              underrun_q, underrun_d, wdog_err_q, wdog_err_d;
  logic              busy_q, busy_d;

  logic [1:0] spd_norm;
  logic       leave_run, capture, pick_os, pick_data, starve;

  always_comb begin
    spd_norm  = (gen_speed == 2'b11) ? 2'b00 : gen_speed;
    leave_run = !tx_en || (spd_norm != ser_gen_speed_q);
    // Inside a burst data owns the lanes; a missing word becomes idle fill.
    pick_os   = !burst_q && os_req;
    pick_data = burst_q ? data_valid : (!os_req && data_valid);
    starve    = burst_q && !data_valid;
    capture   = (state_q == S_IDLE && tx_en) ||
                (state_q == S_RUN && !leave_run && word_tick);
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (tx_en) state_d = S_ARM;
      S_ARM:   state_d = S_RUN;
      S_RUN:   if (leave_run) state_d = S_DRAIN;
      S_DRAIN: if (word_tick && drain_cap_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered-output logic
  always_comb begin
    burst_d         = burst_q;
    drain_cap_d     = drain_cap_q;
    ser_enable_d    = ser_enable_q;
    ser_gen_speed_d = ser_gen_speed_q;
    lane0_d         = lane0_q;
    lane1_d         = lane1_q;
    os_ack_d        = 1'b0;
    data_ack_d      = 1'b0;
    underrun_d      = underrun_q;
    wdog_err_d      = wdog_err_q;

    if (capture) begin
      if (pick_os) begin
        lane0_d = os_l0;
        lane1_d = os_l1;
      end else if (pick_data) begin
        lane0_d = data_l0;
        lane1_d = data_l1;
      end else begin
        lane0_d = '0;
        lane1_d = '0;
      end
      os_ack_d   = pick_os;
      data_ack_d = pick_data;
      if (pick_data) burst_d = !data_last;
      if (starve) underrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        ser_enable_d = 1'b0;
        if (tx_en) ser_gen_speed_d = spd_norm;
      end
      S_ARM: ser_enable_d = 1'b1;
      S_RUN: if (leave_run) begin
        burst_d     = 1'b0;
        drain_cap_d = 1'b0;
      end
      S_DRAIN: if (word_tick) begin
        if (!drain_cap_q) begin
          lane0_d     = '0;
          lane1_d     = '0;
          drain_cap_d = 1'b1;
        end else begin
          ser_enable_d = 1'b0;
          drain_cap_d  = 1'b0;
        end
      end
      default: ;
    endcase

    if (state_q != S_RUN || word_tick)   wdog_cnt_d = '0;
    else if (wdog_cnt_q == CW'(WDOG))    wdog_cnt_d = wdog_cnt_q;
    else                                 wdog_cnt_d = wdog_cnt_q + 1'b1;
    if (wdog_cnt_d == CW'(WDOG)) wdog_err_d = 1'b1;

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_q         <= 1'b0;
      drain_cap_q     <= 1'b0;
      wdog_cnt_q      <= '0;
      ser_enable_q    <= 1'b0;
      ser_gen_speed_q <= 2'b00;
      lane0_q         <= '0;
      lane1_q         <= '0;
      os_ack_q        <= 1'b0;
      data_ack_q      <= 1'b0;
      underrun_q      <= 1'b0;
      wdog_err_q      <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      burst_q         <= burst_d;
      drain_cap_q     <= drain_cap_d;
      wdog_cnt_q      <= wdog_cnt_d;
      ser_enable_q    <= ser_enable_d;
      ser_gen_speed_q <= ser_gen_speed_d;
      lane0_q         <= lane0_d;
      lane1_q         <= lane1_d;
      os_ack_q        <= os_ack_d;
      data_ack_q      <= data_ack_d;
      underrun_q      <= underrun_d;
      wdog_err_q      <= wdog_err_d;
      busy_q          <= busy_d;
    end
  end

  assign ser_enable    = ser_enable_q;
  assign ser_gen_speed = ser_gen_speed_q;
  assign lane0_word    = lane0_q;
  assign lane1_word    = lane1_q;
  assign os_ack        = os_ack_q;
  assign data_ack      = data_ack_q;
  assign underrun      = underrun_q;
  assign wdog_err      = wdog_err_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_tx_lane_scheduler.sv
// Directed bench for tx_lane_scheduler: link bring-up, arbitration, underrun,
// speed change drain/re-arm, watchdog and asynchronous reset.
module tb_tx_lane_scheduler;
  localparam int W = 132;

  logic         clk = 1'b0;
  logic         rst;
  logic         tx_en, word_tick, os_req, data_valid, data_last;
  logic [1:0]   gen_speed;
  logic [W-1:0] os_l0, os_l1, data_l0, data_l1;
  logic         ser_enable, os_ack, data_ack, underrun, wdog_err, busy;
  logic [1:0]   ser_gen_speed;
  logic [W-1:0] lane0_word, lane1_word;

  int checks = 0;
  int errors = 0;

  tx_lane_scheduler #(.WORD_W(W), .WDOG(255)) dut (
    .clk(clk), .rst(rst), .tx_en(tx_en), .gen_speed(gen_speed),
    .word_tick(word_tick), .os_req(os_req), .os_l0(os_l0), .os_l1(os_l1),
    .data_valid(data_valid), .data_last(data_last),
    .data_l0(data_l0), .data_l1(data_l1),
    .ser_enable(ser_enable), .ser_gen_speed(ser_gen_speed),
    .lane0_word(lane0_word), .lane1_word(lane1_word),
    .os_ack(os_ack), .data_ack(data_ack), .underrun(underrun),
    .wdog_err(wdog_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    word_tick = 1'b1;
    step();
    word_tick = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_all(input string tag);
    chk({tag, ".ser_enable"}, W'(ser_enable), W'(0));
    chk({tag, ".ser_gen_speed"}, W'(ser_gen_speed), W'(0));
    chk({tag, ".lane0"}, lane0_word, W'(0));
    chk({tag, ".lane1"}, lane1_word, W'(0));
    chk({tag, ".os_ack"}, W'(os_ack), W'(0));
    chk({tag, ".data_ack"}, W'(data_ack), W'(0));
    chk({tag, ".underrun"}, W'(underrun), W'(0));
    chk({tag, ".wdog_err"}, W'(wdog_err), W'(0));
    chk({tag, ".busy"}, W'(busy), W'(0));
  endtask

  initial begin
    rst = 1'b0; tx_en = 1'b0; gen_speed = 2'b00; word_tick = 1'b0;
    os_req = 1'b0; data_valid = 1'b0; data_last = 1'b0;
    os_l0 = '0; os_l1 = '0; data_l0 = '0; data_l1 = '0;
    #3;
    chk_zero_all("reset");
    step();
    rst = 1'b1;
    step();
    chk("idle.busy", W'(busy), W'(0));

    // Bring-up: first word captured on IDLE exit, enable rises two edges later
    os_req = 1'b1; os_l0 = W'(8'hA5); os_l1 = W'(8'h5A); tx_en = 1'b1;
    step();
    os_req = 1'b0;
    chk("up.os_ack", W'(os_ack), W'(1));
    chk("up.lane0", lane0_word, W'(8'hA5));
    chk("up.lane1", lane1_word, W'(8'h5A));
    chk("up.ser_en_arm", W'(ser_enable), W'(0));
    chk("up.busy", W'(busy), W'(1));
    step();
    chk("up.ser_en_run", W'(ser_enable), W'(1));
    chk("up.ack_drop", W'(os_ack), W'(0));
    chk("up.lane0_hold", lane0_word, W'(8'hA5));

    // Burst of three with OS pending from the second word on
    data_valid = 1'b1; data_l0 = W'(8'hD1); data_l1 = W'(8'hE1); data_last = 1'b0;
    tick();
    chk("b1.data_ack", W'(data_ack), W'(1));
    chk("b1.lane0", lane0_word, W'(8'hD1));
    chk("b1.lane1", lane1_word, W'(8'hE1));
    step();
    chk("b1.ack_drop", W'(data_ack), W'(0));
    os_req = 1'b1; os_l0 = W'(8'h22); os_l1 = W'(8'h23); data_l0 = W'(8'hD2);
    tick();
    chk("b2.data_ack", W'(data_ack), W'(1));
    chk("b2.os_ack", W'(os_ack), W'(0));
    chk("b2.lane0", lane0_word, W'(8'hD2));
    data_l0 = W'(8'hD3); data_last = 1'b1;
    tick();
    chk("b3.data_ack", W'(data_ack), W'(1));
    chk("b3.lane0", lane0_word, W'(8'hD3));
    data_valid = 1'b0; data_last = 1'b0;
    tick();
    chk("b4.os_ack", W'(os_ack), W'(1));
    chk("b4.data_ack", W'(data_ack), W'(0));
    chk("b4.lane1", lane1_word, W'(8'h23));

    // Simultaneous OS and data outside a burst: OS wins
    os_l0 = W'(8'h33); data_valid = 1'b1; data_l0 = W'(8'hD4);
    tick();
    chk("tie.os_ack", W'(os_ack), W'(1));
    chk("tie.data_ack", W'(data_ack), W'(0));
    chk("tie.lane0", lane0_word, W'(8'h33));
    os_req = 1'b0;
    tick();
    chk("tie2.data_ack", W'(data_ack), W'(1));
    chk("tie2.lane0", lane0_word, W'(8'hD4));

    // Underrun inside the open burst: idle fill even with OS pending
    data_valid = 1'b0; os_req = 1'b1; os_l0 = W'(8'h77);
    tick();
    os_req = 1'b0;
    chk("ur.lane0", lane0_word, W'(0));
    chk("ur.lane1", lane1_word, W'(0));
    chk("ur.os_ack", W'(os_ack), W'(0));
    chk("ur.data_ack", W'(data_ack), W'(0));
    chk("ur.underrun", W'(underrun), W'(1));
    step();
    chk("ur.sticky", W'(underrun), W'(1));
    data_valid = 1'b1; data_l0 = W'(8'hD5); data_last = 1'b1;
    tick();
    chk("ur.close_ack", W'(data_ack), W'(1));
    data_valid = 1'b0; data_last = 1'b0;
    tick();
    chk("fill.lane0", lane0_word, W'(0));
    chk("fill.noack", W'({os_ack, data_ack}), W'(0));

    // Speed change 00 -> 10: drain, drop enable, re-arm at new speed
    os_req = 1'b1; os_l0 = W'(8'h44);
    tick();
    chk("pre.lane0", lane0_word, W'(8'h44));
    gen_speed = 2'b10;
    step();
    tick();
    chk("dr.lane0", lane0_word, W'(0));
    chk("dr.os_ack", W'(os_ack), W'(0));
    chk("dr.ser_en", W'(ser_enable), W'(1));
    chk("dr.speed", W'(ser_gen_speed), W'(2'b00));
    tick();
    chk("dr.ser_off", W'(ser_enable), W'(0));
    chk("dr.busy", W'(busy), W'(0));
    os_l0 = W'(8'h55);
    step();
    os_req = 1'b0;
    chk("rearm.os_ack", W'(os_ack), W'(1));
    chk("rearm.lane0", lane0_word, W'(8'h55));
    chk("rearm.speed", W'(ser_gen_speed), W'(2'b10));
    chk("rearm.ser_off", W'(ser_enable), W'(0));
    step();
    chk("rearm.ser_on", W'(ser_enable), W'(1));

    // Watchdog: 255 tick-less RUN cycles
    repeat (254) step();
    chk("wd.before", W'(wdog_err), W'(0));
    step();
    chk("wd.set", W'(wdog_err), W'(1));
    repeat (3) step();
    chk("wd.sticky", W'(wdog_err), W'(1));
    chk("wd.run_on", W'(ser_enable), W'(1));
    chk("wd.underrun_held", W'(underrun), W'(1));

    // Asynchronous reset mid-RUN with a word in flight
    os_req = 1'b1; os_l0 = W'(8'h99); word_tick = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk_zero_all("arst");
    step();
    chk("arst.no_ack", W'(os_ack), W'(0));
    chk("arst.lane0", lane0_word, W'(0));
    word_tick = 1'b0; os_req = 1'b0; tx_en = 1'b0;
    rst = 1'b1;
    step();
    chk("post.busy", W'(busy), W'(0));
    chk("post.ser_en", W'(ser_enable), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
